vram_loader: RTL and testbench
==============================

VRAM_LOADER -- requirements
Module: vram_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2048, meaning the number of words copied per load (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning the width of the VRAM write address (log2 DEPTH).
REQ-003 The block SHALL have parameter ROM_ADDR_W, default 12, meaning the width of the ROM address.
REQ-004 The block SHALL have parameter DATA_W, default 9, meaning the pixel word width.
REQ-005 The block SHALL have parameter ROM_LAT, default 1, range 1..4, meaning the ROM read latency in write_clk cycles.
REQ-006 The block SHALL have parameter ROM_BASE, default 0, meaning the ROM address of the first word copied.
REQ-007 write_clk  input  1  clock; all state is updated on its rising edge.
REQ-008 rst  input  1  reset: asynchronous, active-low.
REQ-009 start  input  1  load request, sampled on a rising edge.
REQ-010 hold  input  1  stall; while high, no new ROM read is issued.
REQ-011 rom_ad  output  ROM_ADDR_W  ROM read address.
REQ-012 rom_ce  output  1  ROM read enable; one read is issued per cycle while high.
REQ-013 rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after the matching rom_ce cycle.
REQ-014 ram_ce  output  1  VRAM write enable.
REQ-015 ram_wad  output  ADDR_W  VRAM write address.
REQ-016 ram_wdata  output  DATA_W  VRAM write data.
REQ-017 busy  output  1  high while the FSM is in FILL or DRAIN.
REQ-018 done  output  1  high while the FSM is in DONE.

Function
REQ-019 The FSM SHALL have the states IDLE, FILL, DRAIN and DONE.
REQ-020 IDLE->FILL and DONE->FILL SHALL occur on an edge where start=1; start SHALL be ignored in FILL and DRAIN.
REQ-021 Entering FILL SHALL clear the issue counter rd_cnt (ADDR_W+1 bits) to 0.
REQ-022 In FILL with hold=0: rom_ce=1, rom_ad=ROM_BASE+rd_cnt (truncated to ROM_ADDR_W), and rd_cnt increments by 1 each cycle.
REQ-023 In FILL with hold=1: rom_ce=0, rd_cnt holds, and in-flight reads continue to drain.
REQ-024 FILL->DRAIN SHALL occur on the edge that issues address index DEPTH-1.
REQ-025 rom_ce SHALL be 0 in IDLE, DRAIN and DONE.
REQ-026 A valid/address shift pipeline of ROM_LAT stages SHALL track each issued read.
REQ-027 ram_ce SHALL be high exactly ROM_LAT cycles after each rom_ce cycle, with ram_wad equal to the issue index (low ADDR_W bits) and ram_wdata equal to rom_data in that cycle.
REQ-028 DRAIN->DONE SHALL occur on the edge after which the pipeline holds no valid entry, so done rises in the cycle after the last ram_ce cycle.
REQ-029 Exactly DEPTH writes SHALL occur per load, at addresses 0..DEPTH-1 in ascending order, with no gaps other than those caused by hold.
REQ-030 busy and done SHALL never be high together.

Reset
REQ-031 When rst=0, the block SHALL asynchronously enter IDLE, clear rd_cnt and the pipeline, and drive rom_ce=0, ram_ce=0, busy=0, done=0, rom_ad=ROM_BASE, ram_wad=0, ram_wdata=0.
REQ-032 Reset asserted mid-load SHALL abort the load immediately, with no further ram_ce until the next start after rst returns high.
REQ-033 Reset release SHALL NOT start a load by itself; a start pulse is required.

Verification
REQ-034 DEPTH=16, ROM_LAT=1, ROM word k=k, single start pulse -> 16 ram_ce cycles on consecutive clocks, wad 0..15, wdata 0..15, done high 1 cycle after the last write, busy high for 17 cycles.
REQ-035 ROM_LAT=3, same stimulus -> first ram_ce 3 cycles after the first rom_ce, still exactly 16 writes, done 1 cycle after wad=15.
REQ-036 hold high for 4 cycles after the 5th issue -> a 4-cycle gap in ram_ce after wad=4, then writes resume at wad=5, with 16 writes in total.
REQ-037 start pulsed again during FILL -> ignored, exactly 16 writes; start pulsed in DONE -> a second full 16-write load, done low during it.
REQ-038 rst driven low after the 7th write -> ram_ce, busy and done low within the same cycle; after release there is no activity until start, then a full load from wad 0.
REQ-039 ROM_BASE=0x100 -> the first rom_ad is 0x100 and the last is 0x10F, while ram_wad still runs 0..15.

Source files
------------

// File: rtl/vram_loader.sv
// rtl/vram_loader.sv - copies DEPTH words from ROM into VRAM after a start request
module vram_loader #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = 11,
    parameter int ROM_ADDR_W = 12,
    parameter int DATA_W     = 9,
    parameter int ROM_LAT    = 1,
    parameter int ROM_BASE   = 0
) (
    input  logic                  write_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic [ROM_ADDR_W-1:0] rom_ad,
    output logic                  rom_ce,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  ram_ce,
    output logic [ADDR_W-1:0]     ram_wad,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [ROM_LAT-1:0]  vld_q, vld_d;
    logic [ROM_LAT-1:0]  vld_shift;
    logic [ADDR_W-1:0]   adr_q [ROM_LAT];
    logic [ADDR_W-1:0]   adr_d [ROM_LAT];

    // Dropping the oldest stage shows what survives the next edge once issuing has stopped.
    assign vld_shift = vld_q << 1;

    always_comb begin
        vld_d[0] = rom_ce;
        adr_d[0] = rd_cnt_q[ADDR_W-1:0];
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            adr_d[i] = adr_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rom_ce   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = FILL;
                    rd_cnt_d = '0;
                end
            end
            FILL: begin
                if (!hold) begin
                    rom_ce   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_shift == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                adr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            vld_q    <= vld_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                adr_q[i] <= adr_d[i];
            end
        end
    end

    assign rom_ad    = ROM_ADDR_W'(ROM_BASE) + ROM_ADDR_W'(rd_cnt_q);
    assign ram_ce    = vld_q[ROM_LAT-1];
    assign ram_wad   = adr_q[ROM_LAT-1];
    assign ram_wdata = ram_ce ? rom_data : '0;
    assign busy      = (state_q == FILL) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_vram_loader.sv
// tb/tb_vram_loader.sv - self-checking bench for vram_loader, two parameter sets side by side
module tb_vram_loader;

    localparam int N     = 1024;
    localparam int DEPTH = 16;

    logic write_clk = 1'b0;
    logic rst       = 1'b0;
    logic start     = 1'b0;
    logic hold      = 1'b0;

    logic [11:0] rom_ad_a, rom_ad_b;
    logic        rom_ce_a, rom_ce_b;
    logic [8:0]  rom_data_a, rom_data_b;
    logic        ram_ce_a, ram_ce_b;
    logic [3:0]  ram_wad_a, ram_wad_b;
    logic [8:0]  ram_wdata_a, ram_wdata_b;
    logic        busy_a, busy_b, done_a, done_b;

    always #5 write_clk = ~write_clk;

    vram_loader #(.DEPTH(16), .ADDR_W(4), .ROM_ADDR_W(12), .DATA_W(9), .ROM_LAT(1), .ROM_BASE(0)) dut_a (
        .write_clk(write_clk), .rst(rst), .start(start), .hold(hold),
        .rom_ad(rom_ad_a), .rom_ce(rom_ce_a), .rom_data(rom_data_a),
        .ram_ce(ram_ce_a), .ram_wad(ram_wad_a), .ram_wdata(ram_wdata_a),
        .busy(busy_a), .done(done_a)
    );

    vram_loader #(.DEPTH(16), .ADDR_W(4), .ROM_ADDR_W(12), .DATA_W(9), .ROM_LAT(3), .ROM_BASE(256)) dut_b (
        .write_clk(write_clk), .rst(rst), .start(start), .hold(hold),
        .rom_ad(rom_ad_b), .rom_ce(rom_ce_b), .rom_data(rom_data_b),
        .ram_ce(ram_ce_b), .ram_wad(ram_wad_b), .ram_wdata(ram_wdata_b),
        .busy(busy_b), .done(done_b)
    );

    // ROM models: unrequested cycles return junk so stray writes are caught
    logic [8:0] mem [4096];
    logic [8:0] pa;
    logic [8:0] pb [3];
    always @(posedge write_clk) begin
        pa    <= rom_ce_a ? mem[rom_ad_a] : 9'($urandom);
        pb[0] <= rom_ce_b ? mem[rom_ad_b] : 9'($urandom);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rom_data_a = pa;
    assign rom_data_b = pb[2];

    int cyc = 0;
    always @(posedge write_clk) cyc <= cyc + 1;

    logic        hold_log [N];
    logic        lce  [2][N], lwce [2][N], lbusy [2][N], ldone [2][N];
    logic [11:0] lad  [2][N];
    logic [3:0]  lwad [2][N];
    logic [8:0]  lwd  [2][N];
    logic        ece  [2][N], ewce [2][N], ebusy [2][N], edone [2][N];
    logic [11:0] ead  [2][N];
    logic [3:0]  ewad [2][N];
    logic [8:0]  ewd  [2][N];

    always @(negedge write_clk) begin
        if (cyc < N) begin
            hold_log[cyc] <= hold;
            lce[0][cyc] <= rom_ce_a;  lad[0][cyc] <= rom_ad_a;  lwce[0][cyc] <= ram_ce_a;
            lwad[0][cyc] <= ram_wad_a; lwd[0][cyc] <= ram_wdata_a;
            lbusy[0][cyc] <= busy_a;  ldone[0][cyc] <= done_a;
            lce[1][cyc] <= rom_ce_b;  lad[1][cyc] <= rom_ad_b;  lwce[1][cyc] <= ram_ce_b;
            lwad[1][cyc] <= ram_wad_b; lwd[1][cyc] <= ram_wdata_b;
            lbusy[1][cyc] <= busy_b;  ldone[1][cyc] <= done_b;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic clear_exp(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            for (int d = 0; d < 2; d++) begin
                ece[d][c] = 0; ead[d][c] = '0; ewce[d][c] = 0; ewad[d][c] = '0;
                ewd[d][c] = '0; ebusy[d][c] = 0; edone[d][c] = 0;
            end
        end
    endtask

    // Load accepted at end of cycle c0: reads go out on every non-hold cycle, writes land LAT later.
    task automatic model_load(input int c0, input int cend);
        clear_exp(c0 + 1, cend);
        for (int d = 0; d < 2; d++) begin
            int lat  = (d == 0) ? 1 : 3;
            int base = (d == 0) ? 0 : 256;
            int k    = 0;
            int last = c0;
            for (int c = c0 + 1; c <= cend && k < DEPTH; c++) begin
                if (!hold_log[c]) begin
                    ece[d][c] = 1;
                    ead[d][c] = 12'(base + k);
                    if (c + lat <= cend) begin
                        ewce[d][c+lat] = 1;
                        ewad[d][c+lat] = 4'(k);
                        ewd[d][c+lat]  = mem[base + k];
                    end
                    last = c;
                    k++;
                end
            end
            for (int c = c0 + 1; c <= cend; c++) begin
                if (k < DEPTH || c <= last + lat) ebusy[d][c] = 1;
                else                              edone[d][c] = 1;
            end
        end
    endtask

    task automatic compare_window(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (lce[d][c] !== ece[d][c]) begin
                    failures++;
                    $display("FAIL rom_ce dut=%0d cyc=%0d got=%b exp=%b", d, c, lce[d][c], ece[d][c]);
                end
                if (ece[d][c]) begin
                    checks++;
                    if (lad[d][c] !== ead[d][c]) begin
                        failures++;
                        $display("FAIL rom_ad dut=%0d cyc=%0d got=%h exp=%h", d, c, lad[d][c], ead[d][c]);
                    end
                end
                checks++;
                if (lwce[d][c] !== ewce[d][c]) begin
                    failures++;
                    $display("FAIL ram_ce dut=%0d cyc=%0d got=%b exp=%b", d, c, lwce[d][c], ewce[d][c]);
                end
                if (ewce[d][c]) begin
                    checks++;
                    if (lwad[d][c] !== ewad[d][c] || lwd[d][c] !== ewd[d][c]) begin
                        failures++;
                        $display("FAIL ram_write dut=%0d cyc=%0d got=%h/%h exp=%h/%h",
                                 d, c, lwad[d][c], lwd[d][c], ewad[d][c], ewd[d][c]);
                    end
                end
                checks++;
                if (lbusy[d][c] !== ebusy[d][c] || ldone[d][c] !== edone[d][c]) begin
                    failures++;
                    $display("FAIL busy_done dut=%0d cyc=%0d got=%b%b exp=%b%b",
                             d, c, lbusy[d][c], ldone[d][c], ebusy[d][c], edone[d][c]);
                end
            end
        end
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        c0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit rand_hold);
        int seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (done_a && done_b) seen = 1;
            else begin
                hold = rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
                tick();
            end
        end
        hold = 1'b0;
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL timeout waiting for done got=%b%b exp=11", done_a, done_b);
        end
        tick();
        tick();
    endtask

    task automatic full_load(input bit rand_hold);
        int c0;
        pulse_start(c0);
        run_until_done(rand_hold);
        model_load(c0, cyc - 1);
        compare_window(c0 + 1, cyc - 1);
    endtask

    task automatic test_reset();
        int cs;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({rom_ce_a, ram_ce_a, busy_a, done_a, rom_ce_b, ram_ce_b, busy_b, done_b} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b%b exp=00000000", rom_ce_a, ram_ce_a,
                     busy_a, done_a, rom_ce_b, ram_ce_b, busy_b, done_b);
        end
        checks++;
        if (rom_ad_a !== 12'h000 || rom_ad_b !== 12'h100) begin
            failures++;
            $display("FAIL reset_rom_ad got=%h/%h exp=000/100", rom_ad_a, rom_ad_b);
        end
        checks++;
        if (ram_wad_a !== 4'd0 || ram_wad_b !== 4'd0 || ram_wdata_a !== 9'd0 || ram_wdata_b !== 9'd0) begin
            failures++;
            $display("FAIL reset_ram got=%h/%h/%h/%h exp=0/0/0/0", ram_wad_a, ram_wad_b, ram_wdata_a, ram_wdata_b);
        end
        rst = 1'b1;
        cs  = cyc;
        for (int i = 0; i < 6; i++) tick();
        clear_exp(cs, cyc - 1);
        compare_window(cs, cyc - 1);
    endtask

    task automatic test_basic();
        full_load(1'b0);
    endtask

    task automatic test_hold();
        int c0;
        pulse_start(c0);
        while (cyc < c0 + 6) tick();
        hold = 1'b1;
        while (cyc < c0 + 10) tick();
        hold = 1'b0;
        run_until_done(1'b0);
        model_load(c0, cyc - 1);
        compare_window(c0 + 1, cyc - 1);
    endtask

    task automatic test_random_hold();
        for (int r = 0; r < 3; r++) full_load(1'b1);
    endtask

    task automatic test_start_ignored_and_restart();
        int c0, c1;
        int o1 = $urandom_range(1, 7);
        int o2 = $urandom_range(9, 16);
        pulse_start(c0);
        while (cyc < c0 + o1) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c0 + o2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(1'b0);
        pulse_start(c1);
        run_until_done(1'b0);
        model_load(c0, cyc - 1);
        model_load(c1, cyc - 1);
        compare_window(c0 + 1, cyc - 1);
    endtask

    task automatic test_reset_mid();
        int c0, cend;
        pulse_start(c0);
        while (cyc < c0 + 9) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_ce_a, busy_a, done_a, ram_ce_b, busy_b, done_b} !== 6'b0) begin
            failures++;
            $display("FAIL abort_same_cycle got=%b%b%b%b%b%b exp=000000",
                     ram_ce_a, busy_a, done_a, ram_ce_b, busy_b, done_b);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        cend = cyc - 1;
        model_load(c0, c0 + 8);
        clear_exp(c0 + 9, cend);
        compare_window(c0 + 1, cend);
        full_load(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 9'($urandom);
        test_reset();
        test_basic();
        test_hold();
        test_random_hold();
        test_start_ignored_and_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
